// File: rtl/ip_frame_demux.sv
// IP frame demultiplexer: routes one IP header + AXI-Stream payload frame to one of
// M_COUNT output ports chosen by `select`, or discards it when `drop` is set.
module ip_frame_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_ENABLE   = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 1,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            s_ip_hdr_valid,
  output logic                            s_ip_hdr_ready,
  input  logic [47:0]                     s_eth_dest_mac,
  input  logic [47:0]                     s_eth_src_mac,
  input  logic [15:0]                     s_eth_type,
  input  logic [3:0]                      s_ip_version,
  input  logic [3:0]                      s_ip_ihl,
  input  logic [5:0]                      s_ip_dscp,
  input  logic [1:0]                      s_ip_ecn,
  input  logic [15:0]                     s_ip_length,
  input  logic [15:0]                     s_ip_identification,
  input  logic [2:0]                      s_ip_flags,
  input  logic [12:0]                     s_ip_fragment_offset,
  input  logic [7:0]                      s_ip_ttl,
  input  logic [7:0]                      s_ip_protocol,
  input  logic [15:0]                     s_ip_header_checksum,
  input  logic [31:0]                     s_ip_source_ip,
  input  logic [31:0]                     s_ip_dest_ip,
  input  logic [DATA_WIDTH-1:0]           s_ip_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]           s_ip_payload_axis_tkeep,
  input  logic                            s_ip_payload_axis_tvalid,
  output logic                            s_ip_payload_axis_tready,
  input  logic                            s_ip_payload_axis_tlast,
  input  logic [ID_WIDTH-1:0]             s_ip_payload_axis_tid,
  input  logic [DEST_WIDTH-1:0]           s_ip_payload_axis_tdest,
  input  logic [USER_WIDTH-1:0]           s_ip_payload_axis_tuser,

  output logic [M_COUNT-1:0]              m_ip_hdr_valid,
  input  logic [M_COUNT-1:0]              m_ip_hdr_ready,
  output logic [M_COUNT*48-1:0]           m_eth_dest_mac,
  output logic [M_COUNT*48-1:0]           m_eth_src_mac,
  output logic [M_COUNT*16-1:0]           m_eth_type,
  output logic [M_COUNT*4-1:0]            m_ip_version,
  output logic [M_COUNT*4-1:0]            m_ip_ihl,
  output logic [M_COUNT*6-1:0]            m_ip_dscp,
  output logic [M_COUNT*2-1:0]            m_ip_ecn,
  output logic [M_COUNT*16-1:0]           m_ip_length,
  output logic [M_COUNT*16-1:0]           m_ip_identification,
  output logic [M_COUNT*3-1:0]            m_ip_flags,
  output logic [M_COUNT*13-1:0]           m_ip_fragment_offset,
  output logic [M_COUNT*8-1:0]            m_ip_ttl,
  output logic [M_COUNT*8-1:0]            m_ip_protocol,
  output logic [M_COUNT*16-1:0]           m_ip_header_checksum,
  output logic [M_COUNT*32-1:0]           m_ip_source_ip,
  output logic [M_COUNT*32-1:0]           m_ip_dest_ip,
  output logic [M_COUNT*DATA_WIDTH-1:0]   m_ip_payload_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]   m_ip_payload_axis_tkeep,
  output logic [M_COUNT-1:0]              m_ip_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]              m_ip_payload_axis_tready,
  output logic [M_COUNT-1:0]              m_ip_payload_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]     m_ip_payload_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]   m_ip_payload_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]   m_ip_payload_axis_tuser,

  input  logic                            enable,
  input  logic                            drop,
  input  logic [$clog2(M_COUNT)-1:0]      select
);

  localparam int SEL_W = $clog2(M_COUNT);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  typedef struct packed {
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [15:0] identification;
    logic [2:0]  flags;
    logic [12:0] fragment_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] header_checksum;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
  } hdr_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_select;
  logic               r_drop;
  logic [M_COUNT-1:0] r_hdr_valid;
  hdr_t               r_hdr;

  logic [M_COUNT-1:0] r_out_valid;
  logic [M_COUNT-1:0] r_tmp_valid;
  beat_t              r_out;
  beat_t              r_tmp;
  logic               r_skid_ready;

  hdr_t               w_hdr_in;
  beat_t              w_in;
  logic               w_hdr_free;
  logic               w_hdr_hs;
  logic               w_drop_eff;
  logic               w_last_beat;
  logic               w_in_beat;
  logic               w_out_ready;
  logic [M_COUNT-1:0] w_hdr_onehot;
  logic [M_COUNT-1:0] w_sel_onehot;
  logic [M_COUNT-1:0] w_in_vec;

  assign w_hdr_in = {s_eth_dest_mac, s_eth_src_mac, s_eth_type, s_ip_version, s_ip_ihl,
                     s_ip_dscp, s_ip_ecn, s_ip_length, s_ip_identification, s_ip_flags,
                     s_ip_fragment_offset, s_ip_ttl, s_ip_protocol, s_ip_header_checksum,
                     s_ip_source_ip, s_ip_dest_ip};

  always_comb begin
    w_in      = '0;
    w_in.data = s_ip_payload_axis_tdata;
    w_in.keep = (KEEP_ENABLE != 0) ? s_ip_payload_axis_tkeep : '1;
    w_in.last = s_ip_payload_axis_tlast;
    w_in.id   = (ID_ENABLE != 0) ? s_ip_payload_axis_tid : '0;
    w_in.dest = (DEST_ENABLE != 0) ? s_ip_payload_axis_tdest : '0;
    w_in.user = (USER_ENABLE != 0) ? s_ip_payload_axis_tuser : '0;
  end

  // Out-of-range select on non-power-of-two port counts is folded into drop.
  assign w_drop_eff   = drop | (int'(select) >= M_COUNT);
  assign w_hdr_onehot = M_COUNT'(1) << select;
  assign w_sel_onehot = M_COUNT'(1) << r_select;

  assign w_hdr_free  = ~|r_hdr_valid | |(r_hdr_valid & m_ip_hdr_ready);
  assign w_last_beat = (r_state == ST_FRAME) & s_ip_payload_axis_tvalid &
                       s_ip_payload_axis_tready & s_ip_payload_axis_tlast;

  // Idle, or finishing the current frame this cycle, lets the next header in.
  assign s_ip_hdr_ready = rst & enable & w_hdr_free & ((r_state == ST_IDLE) | w_last_beat);
  assign w_hdr_hs       = s_ip_hdr_valid & s_ip_hdr_ready;

  assign s_ip_payload_axis_tready = (r_state == ST_FRAME) & (r_drop | r_skid_ready);
  assign w_in_beat = s_ip_payload_axis_tvalid & s_ip_payload_axis_tready & ~r_drop;
  assign w_in_vec  = w_in_beat ? w_sel_onehot : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_select    <= '0;
      r_drop      <= 1'b0;
      r_hdr_valid <= '0;
      r_hdr       <= '0;
    end else begin
      if (|(r_hdr_valid & m_ip_hdr_ready)) r_hdr_valid <= '0;
      if (w_hdr_hs) begin
        r_state  <= ST_FRAME;
        r_select <= select;
        r_drop   <= w_drop_eff;
        r_hdr    <= w_hdr_in;
        if (!w_drop_eff) r_hdr_valid <= w_hdr_onehot;
      end else if (w_last_beat) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Each skid register carries its own one-hot port vector so beats still in flight
  // keep their port after the next header has already updated r_select.
  assign w_out_ready = |(m_ip_payload_axis_tready & r_out_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= '0;
      r_tmp_valid  <= '0;
      r_out        <= '0;
      r_tmp        <= '0;
      r_skid_ready <= 1'b0;
    end else begin
      r_skid_ready <= w_out_ready | (~|r_tmp_valid & (~|r_out_valid | ~w_in_beat));
      if (r_skid_ready) begin
        if (w_out_ready | ~|r_out_valid) begin
          r_out_valid <= w_in_vec;
          r_out       <= w_in;
        end else begin
          r_tmp_valid <= w_in_vec;
          r_tmp       <= w_in;
        end
      end else if (w_out_ready) begin
        r_out_valid <= r_tmp_valid;
        r_out       <= r_tmp;
        r_tmp_valid <= '0;
      end
    end
  end

  assign m_ip_hdr_valid       = r_hdr_valid;
  assign m_eth_dest_mac       = {M_COUNT{r_hdr.eth_dest_mac}};
  assign m_eth_src_mac        = {M_COUNT{r_hdr.eth_src_mac}};
  assign m_eth_type           = {M_COUNT{r_hdr.eth_type}};
  assign m_ip_version         = {M_COUNT{r_hdr.version}};
  assign m_ip_ihl             = {M_COUNT{r_hdr.ihl}};
  assign m_ip_dscp            = {M_COUNT{r_hdr.dscp}};
  assign m_ip_ecn             = {M_COUNT{r_hdr.ecn}};
  assign m_ip_length          = {M_COUNT{r_hdr.length}};
  assign m_ip_identification  = {M_COUNT{r_hdr.identification}};
  assign m_ip_flags           = {M_COUNT{r_hdr.flags}};
  assign m_ip_fragment_offset = {M_COUNT{r_hdr.fragment_offset}};
  assign m_ip_ttl             = {M_COUNT{r_hdr.ttl}};
  assign m_ip_protocol        = {M_COUNT{r_hdr.protocol}};
  assign m_ip_header_checksum = {M_COUNT{r_hdr.header_checksum}};
  assign m_ip_source_ip       = {M_COUNT{r_hdr.source_ip}};
  assign m_ip_dest_ip         = {M_COUNT{r_hdr.dest_ip}};

  assign m_ip_payload_axis_tvalid = r_out_valid;
  assign m_ip_payload_axis_tdata  = {M_COUNT{r_out.data}};
  assign m_ip_payload_axis_tkeep  = {M_COUNT{r_out.keep}};
  assign m_ip_payload_axis_tlast  = {M_COUNT{r_out.last}};
  assign m_ip_payload_axis_tid    = {M_COUNT{r_out.id}};
  assign m_ip_payload_axis_tdest  = {M_COUNT{r_out.dest}};
  assign m_ip_payload_axis_tuser  = {M_COUNT{r_out.user}};

endmodule

// File: tb/tb_ip_frame_demux.sv
// Directed bench for ip_frame_demux: routing, drop, back-to-back, backpressure,
// enable gating and mid-frame reset, with hand-computed expectations.
module tb_ip_frame_demux;

  logic clk;
  logic rst;

  logic         s_ip_hdr_valid, s_ip_hdr_ready;
  logic [47:0]  s_eth_dest_mac, s_eth_src_mac;
  logic [15:0]  s_eth_type;
  logic [3:0]   s_ip_version, s_ip_ihl;
  logic [5:0]   s_ip_dscp;
  logic [1:0]   s_ip_ecn;
  logic [15:0]  s_ip_length, s_ip_identification;
  logic [2:0]   s_ip_flags;
  logic [12:0]  s_ip_fragment_offset;
  logic [7:0]   s_ip_ttl, s_ip_protocol;
  logic [15:0]  s_ip_header_checksum;
  logic [31:0]  s_ip_source_ip, s_ip_dest_ip;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         s_tvalid, s_tready, s_tlast;
  logic [7:0]   s_tid, s_tdest;
  logic [0:0]   s_tuser;

  logic [3:0]   m_ip_hdr_valid, m_ip_hdr_ready;
  logic [191:0] m_eth_dest_mac, m_eth_src_mac;
  logic [63:0]  m_eth_type;
  logic [15:0]  m_ip_version, m_ip_ihl;
  logic [23:0]  m_ip_dscp;
  logic [7:0]   m_ip_ecn;
  logic [63:0]  m_ip_length, m_ip_identification;
  logic [11:0]  m_ip_flags;
  logic [51:0]  m_ip_fragment_offset;
  logic [31:0]  m_ip_ttl, m_ip_protocol;
  logic [63:0]  m_ip_header_checksum;
  logic [127:0] m_ip_source_ip, m_ip_dest_ip;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [3:0]   m_tvalid, m_tready, m_tlast;
  logic [31:0]  m_tid, m_tdest;
  logic [3:0]   m_tuser;

  logic         enable, drop;
  logic [1:0]   select;

  ip_frame_demux dut (
    .clk(clk), .rst(rst),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_ip_version(s_ip_version), .s_ip_ihl(s_ip_ihl), .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn),
    .s_ip_length(s_ip_length), .s_ip_identification(s_ip_identification),
    .s_ip_flags(s_ip_flags), .s_ip_fragment_offset(s_ip_fragment_offset),
    .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
    .s_ip_header_checksum(s_ip_header_checksum),
    .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
    .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
    .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tid(s_tid),
    .s_ip_payload_axis_tdest(s_tdest), .s_ip_payload_axis_tuser(s_tuser),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_ip_version(m_ip_version), .m_ip_ihl(m_ip_ihl), .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn),
    .m_ip_length(m_ip_length), .m_ip_identification(m_ip_identification),
    .m_ip_flags(m_ip_flags), .m_ip_fragment_offset(m_ip_fragment_offset),
    .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
    .m_ip_header_checksum(m_ip_header_checksum),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
    .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(m_tready),
    .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tid(m_tid),
    .m_ip_payload_axis_tdest(m_tdest), .m_ip_payload_axis_tuser(m_tuser),
    .enable(enable), .drop(drop), .select(select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  port;
    logic [63:0] data;
    logic        last;
    logic [7:0]  tid;
  } beat_t;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] dip;
  } hdr_rec_t;

  beat_t    beats[$];
  hdr_rec_t hdrs[$];
  int       hdr_in_cyc[$];
  int       last_in_cyc[$];
  int       cyc = 0;
  int       multi_err = 0;
  int       any_valid = 0;

  int total = 0;
  int bad = 0;
  bit bp_on = 1'b0;

  // Observation at the falling edge: a valid&ready seen here completes on the next rise.
  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      if (s_ip_hdr_valid && s_ip_hdr_ready) hdr_in_cyc.push_back(cyc);
      if (s_tvalid && s_tready && s_tlast) last_in_cyc.push_back(cyc);
      for (int p = 0; p < 4; p++) begin
        if (m_tvalid[p] && m_tready[p])
          beats.push_back('{port: 2'(p), data: m_tdata[p*64 +: 64], last: m_tlast[p],
                            tid: m_tid[p*8 +: 8]});
        if (m_ip_hdr_valid[p] && m_ip_hdr_ready[p])
          hdrs.push_back('{port: 2'(p), dip: m_ip_dest_ip[p*32 +: 32]});
      end
      if ($countones(m_tvalid) > 1 || $countones(m_ip_hdr_valid) > 1) multi_err++;
      if (m_tvalid != 4'b0 || m_ip_hdr_valid != 4'b0) any_valid++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "time limit reached");
  end

  task automatic drive_hdr(input logic [1:0] sel, input logic drp, input logic [31:0] dip,
                           output bit ok);
    ok = 1'b0;
    s_ip_hdr_valid = 1'b1;
    select = sel;
    drop = drp;
    s_ip_dest_ip = dip;
    for (int w = 0; w < 60 && !ok; w++) begin
      @(negedge clk);
      if (s_ip_hdr_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_ip_hdr_valid = 1'b0;
    drop = 1'b0;
  endtask

  task automatic drive_beats(input int n, input logic [63:0] base, input bit with_last,
                             output int stalls, output bit ok);
    bit got;
    stalls = 0;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      s_tvalid = 1'b1;
      s_tdata = base + 64'(k);
      s_tlast = with_last && (k == n - 1);
      for (int w = 0; w < 60 && !got; w++) begin
        @(negedge clk);
        if (s_tready === 1'b1) got = 1'b1;
        else stalls++;
        @(posedge clk); #1;
      end
      if (!got) ok = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    enable = 1'b1;
    s_ip_hdr_valid = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (s_ip_hdr_ready !== 1'b0) begin bad++; $display("FAIL reset_hdr_ready: got %b want 0", s_ip_hdr_ready); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    total++; if (m_ip_hdr_valid !== 4'b0) begin bad++; $display("FAIL reset_hdr_valid: got %b want 0000", m_ip_hdr_valid); end
    total++; if (m_tvalid !== 4'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0000", m_tvalid); end
    s_ip_hdr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit ok, okb;
    int st;
    int b0 = beats.size();
    int h0 = hdrs.size();
    drive_hdr(2'd2, 1'b0, 32'hC0A80102, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_hdr_accept: got timeout want handshake"); end
    @(negedge clk);
    total++; if (m_ip_hdr_valid !== 4'b0100) begin bad++; $display("FAIL basic_hdr_valid: got %b want 0100", m_ip_hdr_valid); end
    total++; if (m_ip_dest_ip[64 +: 32] !== 32'hC0A80102) begin bad++; $display("FAIL basic_dest_ip: got %h want c0a80102", m_ip_dest_ip[64 +: 32]); end
    total++; if (m_ip_ttl !== {4{8'h40}}) begin bad++; $display("FAIL basic_ttl_repl: got %h want 40404040", m_ip_ttl); end
    @(posedge clk); #1;
    drive_beats(3, 64'hA0, 1'b1, st, okb);
    drain(4);
    total++; if (!okb || st != 0) begin bad++; $display("FAIL basic_in_stalls: got ok=%0d stalls=%0d want ok=1 stalls=0", okb, st); end
    total++; if (beats.size() - b0 != 3) begin bad++; $display("FAIL basic_beat_count: got %0d want 3", beats.size() - b0); end
    for (int i = 0; i < 3 && b0 + i < beats.size(); i++) begin
      total++;
      if (beats[b0+i] !== '{port: 2'd2, data: 64'hA0 + 64'(i), last: (i == 2), tid: 8'h5A}) begin
        bad++;
        $display("FAIL basic_beat%0d: got port=%0d data=%h last=%b tid=%h want port=2 data=%h last=%b tid=5a",
                 i, beats[b0+i].port, beats[b0+i].data, beats[b0+i].last, beats[b0+i].tid,
                 64'hA0 + 64'(i), (i == 2));
      end
    end
    total++; if (hdrs.size() - h0 != 1) begin bad++; $display("FAIL basic_hdr_count: got %0d want 1", hdrs.size() - h0); end
  endtask

  task automatic test_drop;
    bit ok, okb;
    int st;
    int b0 = beats.size();
    int h0 = hdrs.size();
    int v0 = any_valid;
    drive_hdr(2'd1, 1'b1, 32'h0A0A0A0A, ok);
    drive_beats(4, 64'hD0, 1'b1, st, okb);
    drain(4);
    total++; if (!ok || !okb || st != 0) begin bad++; $display("FAIL drop_tready: got ok=%0d/%0d stalls=%0d want 1/1 stalls=0", ok, okb, st); end
    total++; if (any_valid != v0 || beats.size() != b0 || hdrs.size() != h0) begin
      bad++; $display("FAIL drop_silent: got valid_cycles=%0d beats=%0d hdrs=%0d want 0 0 0",
                      any_valid - v0, beats.size() - b0, hdrs.size() - h0);
    end
    b0 = beats.size();
    drive_hdr(2'd0, 1'b0, 32'h0B0B0B0B, ok);
    drive_beats(1, 64'hE0, 1'b1, st, okb);
    drain(4);
    total++; if (!ok || beats.size() - b0 != 1 || (beats.size() > b0 && beats[b0].port !== 2'd0)) begin
      bad++; $display("FAIL drop_next_frame: got ok=%0d beats=%0d want ok=1 beats=1 on port 0", ok, beats.size() - b0);
    end
  endtask

  task automatic test_back_to_back;
    bit oka, okb, okb2, okc;
    int st, st2;
    int b0 = beats.size();
    int h0 = hdrs.size();
    int hi0 = hdr_in_cyc.size();
    int li0 = last_in_cyc.size();
    drive_hdr(2'd0, 1'b0, 32'hAAAA0000, oka);
    @(negedge clk);
    total++; if (m_ip_hdr_valid !== 4'b0001) begin bad++; $display("FAIL b2b_hdr_a: got %b want 0001", m_ip_hdr_valid); end
    @(posedge clk); #1;
    fork
      drive_beats(3, 64'hB0, 1'b1, st, okb);
      drive_hdr(2'd3, 1'b0, 32'hBBBB0003, okc);
    join
    drive_beats(2, 64'hC0, 1'b1, st2, okb2);
    drain(4);
    total++; if (!(oka && okb && okc && okb2)) begin bad++; $display("FAIL b2b_handshakes: got %0d%0d%0d%0d want 1111", oka, okb, okc, okb2); end
    if (hdr_in_cyc.size() >= hi0 + 2 && last_in_cyc.size() >= li0 + 1) begin
      total++;
      if (hdr_in_cyc[hi0+1] < last_in_cyc[li0]) begin
        bad++; $display("FAIL b2b_hdr_timing: got B accepted cycle %0d want >= A tlast cycle %0d",
                        hdr_in_cyc[hi0+1], last_in_cyc[li0]);
      end
    end else begin
      total++; bad++;
      $display("FAIL b2b_hdr_timing: got hdr_hs=%0d tlast_hs=%0d want 2 and 1",
               hdr_in_cyc.size() - hi0, last_in_cyc.size() - li0);
    end
    total++; if (hdrs.size() - h0 != 2 || hdrs[h0].port !== 2'd0 || hdrs[h0+1].port !== 2'd3) begin
      bad++; $display("FAIL b2b_hdr_ports: got count=%0d want ports 0 then 3", hdrs.size() - h0);
    end
    total++; if (beats.size() - b0 != 5) begin bad++; $display("FAIL b2b_beat_count: got %0d want 5", beats.size() - b0); end
    for (int i = 0; i < 5 && b0 + i < beats.size(); i++) begin
      logic [1:0]  ep;
      logic [63:0] ed;
      ep = (i < 3) ? 2'd0 : 2'd3;
      ed = (i < 3) ? 64'hB0 + 64'(i) : 64'hC0 + 64'(i - 3);
      total++;
      if (beats[b0+i].port !== ep || beats[b0+i].data !== ed || beats[b0+i].last !== (i == 2 || i == 4)) begin
        bad++; $display("FAIL b2b_beat%0d: got port=%0d data=%h last=%b want port=%0d data=%h",
                        i, beats[b0+i].port, beats[b0+i].data, beats[b0+i].last, ep, ed);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok, okb;
    int st;
    int b0 = beats.size();
    drive_hdr(2'd1, 1'b0, 32'h01010101, ok);
    bp_on = 1'b1;
    fork
      for (int c = 0; c < 400 && bp_on; c++) begin
        @(posedge clk); #1;
        m_tready[1] = ~m_tready[1];
      end
    join_none
    drive_beats(8, 64'h0, 1'b1, st, okb);
    drain(24);
    bp_on = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    m_tready = 4'b1111;
    drain(2);
    total++; if (!ok || !okb) begin bad++; $display("FAIL bp_handshakes: got %0d%0d want 11", ok, okb); end
    total++; if (beats.size() - b0 != 8) begin bad++; $display("FAIL bp_beat_count: got %0d want 8", beats.size() - b0); end
    for (int i = 0; i < 8 && b0 + i < beats.size(); i++) begin
      total++;
      if (beats[b0+i].port !== 2'd1 || beats[b0+i].data !== 64'(i) || beats[b0+i].last !== (i == 7)) begin
        bad++; $display("FAIL bp_beat%0d: got port=%0d data=%h last=%b want port=1 data=%h last=%b",
                        i, beats[b0+i].port, beats[b0+i].data, beats[b0+i].last, 64'(i), (i == 7));
      end
    end
  endtask

  task automatic test_enable;
    bit ok, okb, seen;
    int st;
    int h0 = hdrs.size();
    enable = 1'b0;
    s_ip_hdr_valid = 1'b1;
    select = 2'd1;
    s_ip_dest_ip = 32'hE0E0E0E0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (s_ip_hdr_ready !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen) begin bad++; $display("FAIL enable_gate_ready: got ready=1 want 0"); end
    total++; if (m_ip_hdr_valid !== 4'b0 || hdrs.size() != h0) begin bad++; $display("FAIL enable_gate_out: got %b want 0000", m_ip_hdr_valid); end
    enable = 1'b1;
    drive_hdr(2'd1, 1'b0, 32'hE0E0E0E0, ok);
    @(negedge clk);
    total++; if (!ok || m_ip_hdr_valid !== 4'b0010) begin bad++; $display("FAIL enable_accept: got ok=%0d valid=%b want 1 0010", ok, m_ip_hdr_valid); end
    @(posedge clk); #1;
    drive_beats(1, 64'hF0, 1'b1, st, okb);
    drain(4);
  endtask

  task automatic test_reset_mid_frame;
    bit ok, okb;
    int st, b0, h0;
    drive_hdr(2'd2, 1'b0, 32'h22222222, ok);
    drive_beats(2, 64'h100, 1'b0, st, okb);
    s_tvalid = 1'b1;
    s_tdata = 64'h102;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (m_tvalid !== 4'b0 || m_ip_hdr_valid !== 4'b0) begin
      bad++; $display("FAIL midrst_valids: got tvalid=%b hdr_valid=%b want 0000 0000", m_tvalid, m_ip_hdr_valid);
    end
    total++; if (s_tready !== 1'b0 || s_ip_hdr_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_readies: got tready=%b hdr_ready=%b want 0 0", s_tready, s_ip_hdr_ready);
    end
    s_tvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    b0 = beats.size();
    h0 = hdrs.size();
    drive_hdr(2'd3, 1'b0, 32'h33333333, ok);
    drive_beats(2, 64'h200, 1'b1, st, okb);
    drain(4);
    total++; if (!ok || !okb || hdrs.size() - h0 != 1 || (hdrs.size() > h0 && hdrs[h0] !== '{port: 2'd3, dip: 32'h33333333})) begin
      bad++; $display("FAIL midrst_fresh_hdr: got ok=%0d/%0d hdrs=%0d want 1/1 one header on port 3", ok, okb, hdrs.size() - h0);
    end
    total++; if (beats.size() - b0 != 2 || (beats.size() >= b0 + 2 &&
                 (beats[b0].port !== 2'd3 || beats[b0].data !== 64'h200 || beats[b0+1].data !== 64'h201 || beats[b0+1].last !== 1'b1))) begin
      bad++; $display("FAIL midrst_fresh_beats: got count=%0d want 2 beats 200,201 on port 3", beats.size() - b0);
    end
  endtask

  initial begin
    s_ip_hdr_valid = 1'b0;
    s_eth_dest_mac = 48'h0200_0000_0001;
    s_eth_src_mac  = 48'h0200_0000_0002;
    s_eth_type     = 16'h0800;
    s_ip_version   = 4'd4;
    s_ip_ihl       = 4'd5;
    s_ip_dscp      = 6'd0;
    s_ip_ecn       = 2'd0;
    s_ip_length    = 16'd100;
    s_ip_identification = 16'h1234;
    s_ip_flags     = 3'b010;
    s_ip_fragment_offset = 13'd0;
    s_ip_ttl       = 8'h40;
    s_ip_protocol  = 8'h11;
    s_ip_header_checksum = 16'hBEEF;
    s_ip_source_ip = 32'h0A000001;
    s_ip_dest_ip   = 32'h0;
    s_tdata = '0; s_tkeep = 8'hFF; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tid = 8'h5A; s_tdest = 8'h00; s_tuser = 1'b0;
    m_ip_hdr_ready = 4'b1111;
    m_tready = 4'b1111;
    enable = 1'b0; drop = 1'b0; select = 2'd0;

    test_reset();
    test_basic();
    test_drop();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_reset_mid_frame();

    total++; if (multi_err != 0) begin bad++; $display("FAIL onehot_outputs: got %0d multi-port cycles want 0", multi_err); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
